// File: rtl/contiguous_run_iterator.sv
// rtl/contiguous_run_iterator.sv - emits each contiguous run of 1 bits in a word, rightmost first
// Define CONTIGUOUS_RUN_ITERATOR_POSITION_EN to add the output_run_lsb/output_run_length ports.
module contiguous_run_iterator #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic [WORD_WIDTH-1:0]         input_word,
  input  logic                          input_valid,
  output logic                          input_ready,
  output logic [WORD_WIDTH-1:0]         output_run,
  output logic                          output_last,
  output logic                          output_valid,
`ifdef CONTIGUOUS_RUN_ITERATOR_POSITION_EN
  output logic [$clog2(WORD_WIDTH):0]   output_run_lsb,
  output logic [$clog2(WORD_WIDTH):0]   output_run_length,
`endif
  input  logic                          output_ready
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e                 state_q, state_d;
  logic [WORD_WIDTH-1:0]  rem_q, rem_d;
  logic [WORD_WIDTH-1:0]  low_bit;
  logic [WORD_WIDTH-1:0]  nxt;
  logic [WORD_WIDTH-1:0]  run;

  // Adding the isolated lowest bit ripples through the rightmost run; the
  // carry out of the MSB is intentionally dropped by the modular width.
  assign low_bit = rem_q & (~rem_q + WORD_WIDTH'(1));
  assign nxt     = (low_bit + rem_q) & rem_q;
  assign run     = rem_q ^ nxt;

  always_comb begin
    output_valid = (state_q == EMIT);
    input_ready  = (state_q == IDLE);
    output_run   = output_valid ? run : '0;
    output_last  = output_valid && (nxt == '0);
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (input_valid) begin
          rem_d   = input_word;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (output_ready) begin
          if (nxt == '0) begin
            rem_d   = '0;
            state_d = IDLE;
          end else begin
            rem_d = nxt;
          end
        end
      end
      default: begin
        rem_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

`ifdef CONTIGUOUS_RUN_ITERATOR_POSITION_EN
  localparam int POS_W = $clog2(WORD_WIDTH) + 1;

  always_comb begin
    output_run_lsb    = '0;
    output_run_length = '0;
    for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
      if (output_run[i]) output_run_lsb = POS_W'(i);
    end
    for (int i = 0; i < WORD_WIDTH; i++) begin
      output_run_length = output_run_length + POS_W'(output_run[i]);
    end
  end
`endif

endmodule

// File: tb/tb_contiguous_run_iterator.sv
// tb/tb_contiguous_run_iterator.sv - self-checking bench for contiguous_run_iterator
// Exercises CONTIGUOUS_RUN_ITERATOR_POSITION_EN outputs when that macro is defined.
module tb_contiguous_run_iterator;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic [7:0] input_word = '0;
  logic       input_valid = 1'b0;
  logic       input_ready;
  logic [7:0] output_run;
  logic       output_last;
  logic       output_valid;
  logic       output_ready = 1'b0;
`ifdef CONTIGUOUS_RUN_ITERATOR_POSITION_EN
  logic [3:0] output_run_lsb;
  logic [3:0] output_run_length;
`endif

  int checks = 0;
  int failures = 0;

  contiguous_run_iterator #(.WORD_WIDTH(8)) dut (
    .clock        (clock),
    .clear        (clear),
    .input_word   (input_word),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_run   (output_run),
    .output_last  (output_last),
    .output_valid (output_valid),
`ifdef CONTIGUOUS_RUN_ITERATOR_POSITION_EN
    .output_run_lsb    (output_run_lsb),
    .output_run_length (output_run_length),
`endif
    .output_ready (output_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] word;
    int         n;
    logic [7:0] runs [4];
  } vec_t;

  vec_t       tbl [7];
  logic [7:0] exp_q [$];
  logic [7:0] got_run [$];
  logic       got_last [$];
`ifdef CONTIGUOUS_RUN_ITERATOR_POSITION_EN
  logic [3:0] got_lsb [$];
  logic [3:0] got_len [$];
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: scan bits LSB to MSB collecting maximal runs of ones.
  task automatic model_runs(input logic [7:0] w);
    logic [7:0] mask;
    exp_q.delete();
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      if (w[i]) mask[i] = 1'b1;
      else if (mask != 0) begin
        exp_q.push_back(mask);
        mask = '0;
      end
    end
    if (mask != 0) exp_q.push_back(mask);
    if (exp_q.size() == 0) exp_q.push_back(8'h00);
  endtask

  task automatic accept_word(input logic [7:0] w);
    @(negedge clock);
    input_word   = w;
    input_valid  = 1'b1;
    output_ready = 1'b0;
    check("input_ready_idle", input_ready, 1);
    check("valid_low_idle", output_valid, 0);
    @(negedge clock);
    input_valid = 1'b0;
    input_word  = $urandom_range(255);
    check("first_beat_latency", output_valid, 1);
  endtask

  // Collects every beat of one word; stall_pct is the chance of output_ready=0.
  task automatic do_word(input logic [7:0] w, input int stall_pct);
    bit         done;
    bit         stalled;
    logic [7:0] held;
    got_run.delete();
    got_last.delete();
`ifdef CONTIGUOUS_RUN_ITERATOR_POSITION_EN
    got_lsb.delete();
    got_len.delete();
`endif
    done    = 0;
    stalled = 0;
    held    = '0;
    accept_word(w);
    for (int c = 0; c < 64 && !done; c++) begin
      if (c > 0) @(negedge clock);
      if (stalled) check("hold_run", output_run, held);
      if (!output_valid) begin
        check("valid_during_emit", output_valid, 1);
        break;
      end
      output_ready = ($urandom_range(99) >= stall_pct);
      if (output_ready) begin
        got_run.push_back(output_run);
        got_last.push_back(output_last);
`ifdef CONTIGUOUS_RUN_ITERATOR_POSITION_EN
        got_lsb.push_back(output_run_lsb);
        got_len.push_back(output_run_length);
`endif
        done    = output_last;
        stalled = 0;
      end else begin
        stalled = 1;
        held    = output_run;
      end
    end
    if (!done) check("word_completed", 0, 1);
    @(negedge clock);
    output_ready = 1'b0;
    check("input_ready_after_last", input_ready, 1);
    check("valid_low_after_last", output_valid, 0);
  endtask

  task automatic compare_got();
    check("beat_count", got_run.size(), exp_q.size());
    for (int i = 0; i < got_run.size() && i < exp_q.size(); i++) begin
      check("beat_run", got_run[i], exp_q[i]);
      check("beat_last", got_last[i], (i == exp_q.size() - 1));
`ifdef CONTIGUOUS_RUN_ITERATOR_POSITION_EN
      begin
        logic [3:0] el;
        el = '0;
        for (int b = 7; b >= 0; b--) if (exp_q[i][b]) el = 4'(b);
        check("beat_lsb", got_lsb[i], el);
        check("beat_length", got_len[i], $countones(exp_q[i]));
      end
`endif
    end
  endtask

  initial begin
    tbl[0] = '{word: 8'b01011100, n: 2, runs: '{8'b00011100, 8'b01000000, 8'h00, 8'h00}};
    tbl[1] = '{word: 8'h00, n: 1, runs: '{8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[2] = '{word: 8'hFF, n: 1, runs: '{8'hFF, 8'h00, 8'h00, 8'h00}};
    tbl[3] = '{word: 8'hAA, n: 4, runs: '{8'h02, 8'h08, 8'h20, 8'h80}};
    tbl[4] = '{word: 8'h80, n: 1, runs: '{8'h80, 8'h00, 8'h00, 8'h00}};
    tbl[5] = '{word: 8'hC3, n: 2, runs: '{8'h03, 8'hC0, 8'h00, 8'h00}};
    tbl[6] = '{word: 8'h30, n: 1, runs: '{8'h30, 8'h00, 8'h00, 8'h00}};

    repeat (3) @(negedge clock);
    check("reset_valid", output_valid, 0);
    check("reset_ready", input_ready, 1);
    check("reset_run", output_run, 0);
    check("reset_last", output_last, 0);
`ifdef CONTIGUOUS_RUN_ITERATOR_POSITION_EN
    check("reset_lsb", output_run_lsb, 0);
    check("reset_length", output_run_length, 0);
`endif
    clear = 1'b0;

    for (int t = 0; t < 7; t++) begin
      do_word(tbl[t].word, 0);
      check("tbl_beat_count", got_run.size(), tbl[t].n);
      for (int i = 0; i < tbl[t].n && i < got_run.size(); i++) begin
        check("tbl_run", got_run[i], tbl[t].runs[i]);
        check("tbl_last", got_last[i], (i == tbl[t].n - 1));
      end
`ifdef CONTIGUOUS_RUN_ITERATOR_POSITION_EN
      if (tbl[t].word == 8'b01011100 && got_run.size() == 2) begin
        check("pos_5c_lsb1", got_lsb[0], 2);
        check("pos_5c_len1", got_len[0], 3);
        check("pos_5c_lsb2", got_lsb[1], 6);
        check("pos_5c_len2", got_len[1], 1);
      end
      if (tbl[t].word == 8'h00 && got_run.size() == 1) begin
        check("pos_00_lsb", got_lsb[0], 0);
        check("pos_00_len", got_len[0], 0);
      end
`endif
    end

    // 8'hAA with a three-cycle stall on the 08 beat.
    accept_word(8'hAA);
    output_ready = 1'b1;
    check("stall_beat1", output_run, 8'h02);
    @(negedge clock);
    output_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stall_run", output_run, 8'h08);
      check("stall_valid", output_valid, 1);
      check("stall_last", output_last, 0);
      @(negedge clock);
    end
    output_ready = 1'b1;
    check("stall_release", output_run, 8'h08);
    @(negedge clock);
    check("stall_beat3", output_run, 8'h20);
    @(negedge clock);
    check("stall_beat4", output_run, 8'h80);
    check("stall_beat4_last", output_last, 1);
    @(negedge clock);
    output_ready = 1'b0;
    check("stall_done_ready", input_ready, 1);

    // clear during beat 08 of 8'hAA, racing a consumer handshake.
    accept_word(8'hAA);
    output_ready = 1'b1;
    @(negedge clock);
    check("clr_beat2", output_run, 8'h08);
    clear = 1'b1;
    @(negedge clock);
    clear        = 1'b0;
    output_ready = 1'b0;
    check("clr_valid", output_valid, 0);
    check("clr_ready", input_ready, 1);
    check("clr_run", output_run, 0);
    do_word(8'h30, 0);
    check("clr_after_count", got_run.size(), 1);
    if (got_run.size() > 0) begin
      check("clr_after_run", got_run[0], 8'h30);
      check("clr_after_last", got_last[0], 1);
    end

    // Randomized words and backpressure against the reference model.
    for (int r = 0; r < 200; r++) begin
      logic [7:0] w;
      w = 8'($urandom_range(255));
      do_word(w, 30);
      model_runs(w);
      compare_got();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
